sdfm_regmap_nch: RTL
====================

# sdfm_regmap_nch

Parametrised register map for the sigma-delta filter module (SDFM), generalised to NCH filter channels on a single clock domain. It decodes the host register bus, holds the global control and per-channel filter parameter registers, and latches per-channel filter results. It adds data-ready/overrun status flags with write-1-to-clear and auto-acknowledge-on-read, and a maskable interrupt output. It sits between the host bus and the filter channel array.

## Interface
- NCH, 4, number of filter channels, legal 1..8
- DEVADDR, 8'h07, device select value compared against ADDR[15:8]
- SYSCLK  in  1  system clock; all logic on rising edge
- SYSRSTn  in  1  system reset, asynchronous, active-low
- WR  in  1  write strobe, one cycle per access
- RD  in  1  read strobe, one cycle per access
- ADDR  in  16  register address; [15:8] device, [7:0] register offset
- WDATA  in  32  write data, sampled when WR=1
- RDATA  out  32  registered read data
- RDVALID  out  1  one-cycle pulse qualifying RDATA
- filt_data_out  in  NCH*32  filter results, channel i at [32i+31:32i]
- filt_data_update  in  NCH  per-channel one-cycle result-valid pulse
- reg_rsten, reg_clken  out  1 each  CTL[0], CTL[1]
- reg_filtdec  out  NCH*8  DOSR per channel
- reg_inmode  out  NCH*2  MOD per channel
- reg_clkdiv  out  NCH*4  DIV per channel
- reg_filten, reg_filtask  out  NCH each  FEN, AEN per channel
- reg_filtst  out  NCH*2  STF per channel
- irq  out  1  registered interrupt request

## Operation
- Select: sel = (ADDR[15:8]==DEVADDR) && (WR||RD). Offsets: CTL 0x08; STAT 0x10; IER 0x14; DFPARMi 0x20+4i; FDATAi 0x40+4i (i<NCH). Offsets for i>=NCH are unmapped.
- CTL: bit0 RSTEN, bit1 CLKEN; RW; other bits read 0.
- DFPARMi: [7:0] DOSR, [9:8] MOD, [15:12] DIV, [16] FEN, [17] AEN, [21:20] STF; RW; unused bits read 0.
- FDATAi: read-only. Loaded with filt_data_out slice i on the cycle filt_data_update[i]=1, independent of every other channel. Writes are ignored.
- STAT: [NCH-1:0] DRDY, [8+NCH-1:8] OVF. Bits read 0 above NCH.
  - DRDY[i] sets on filt_data_update[i].
  - OVF[i] sets on filt_data_update[i] while DRDY[i]=1 and DRDY[i] is not being cleared in the same cycle.
  - Writing 1 clears a bit; writing 0 has no effect.
  - A read of FDATAi with AEN[i]=1 clears DRDY[i].
- Priority within one cycle: set beats clear for both DRDY and OVF.
- IER: same bit layout as STAT; RW; enables the corresponding STAT bits.
- irq: registered; irq <= |(STAT & IER), evaluated on next-state values.
- Unmapped offsets: writes have no effect; reads return 0 with RDVALID.
- Non-selected device: no writes occur, RDVALID stays 0, RDATA returns to 0.

## Timing
- Reset (SYSRSTn low, asynchronous): every register and output is 0, including RDATA, RDVALID and irq. Reset asserted mid-access aborts the access with no partial update.
- Write: register updated at the rising edge where WR=1; the new value is visible on outputs the same edge.
- Read: RDATA and RDVALID are valid one cycle after the RD edge. RDATA returns the pre-edge register value. RDATA is 0 in any cycle where RDVALID=0.
- WR and RD in the same cycle to the same offset: the read returns the old value, and the write takes effect.
- FDATAi read in the same cycle as update[i]: returns the old data. DRDY[i] ends at 1. OVF[i] is not set.
- Flag set at edge N: STAT shows the flag after edge N, and irq is high after edge N (irq is computed from next-state values).
- No back-pressure: one access per cycle, back-to-back accesses supported.

## Test plan
- Reset: drive SYSRSTn low mid-stream, then release. Required: all outputs and registers 0; a read of CTL returns 0x00000000 with RDVALID 1 cycle later.
- NCH=4: write 0x0031_A340 to 0x28 (DFPARM2). Required: reg_filtdec[23:16]=0x40, reg_inmode[5:4]=3, reg_clkdiv[11:8]=0xA, reg_filten[2]=1, reg_filtask[2]=0, reg_filtst[5:4]=3. A read of 0x28 returns 0x0031_A340.
- IER=0x1 and AEN0=1; pulse update[0] with data 0x12345678. Required: DRDY0=1 and irq=1. A read of 0x40 returns 0x12345678; afterwards DRDY0=0 and irq=0 one cycle later.
- Pulse update[1] twice with no acknowledge. Required: STAT=0x0202. Writing 0x0202 to STAT clears it to 0. Writing 0 to STAT changes nothing.
- With DRDY3=1, write 0x08 to STAT in the same cycle as update[3]. Required: DRDY3 stays 1 and OVF3 stays 0.
- ADDR=0x0808 and ADDR=0x0760 (unmapped for NCH=4). Required: no register changes. The first read gives RDVALID=0; the second gives RDVALID=1 with RDATA=0.

Source files
------------

// File: rtl/sdfm_regmap_nch.sv
// Register map for an NCH-channel sigma-delta filter array.
// Decodes the host register bus, holds global control and per-channel
// filter parameters, latches per-channel filter results, and keeps
// data-ready / overrun status flags that drive a maskable interrupt.
module sdfm_regmap_nch #(
  parameter int         NCH     = 4,
  parameter logic [7:0] DEVADDR = 8'h07
) (
  input  logic              SYSCLK,
  input  logic              SYSRSTn,
  input  logic              WR,
  input  logic              RD,
  input  logic [15:0]       ADDR,
  input  logic [31:0]       WDATA,
  output logic [31:0]       RDATA,
  output logic              RDVALID,
  input  logic [NCH*32-1:0] filt_data_out,
  input  logic [NCH-1:0]    filt_data_update,
  output logic              reg_rsten,
  output logic              reg_clken,
  output logic [NCH*8-1:0]  reg_filtdec,
  output logic [NCH*2-1:0]  reg_inmode,
  output logic [NCH*4-1:0]  reg_clkdiv,
  output logic [NCH-1:0]    reg_filten,
  output logic [NCH-1:0]    reg_filtask,
  output logic [NCH*2-1:0]  reg_filtst,
  output logic              irq
);

  localparam logic [7:0] OFF_CTL   = 8'h08;
  localparam logic [7:0] OFF_STAT  = 8'h10;
  localparam logic [7:0] OFF_IER   = 8'h14;
  localparam logic [7:0] OFF_PARM  = 8'h20;
  localparam logic [7:0] OFF_FDATA = 8'h40;

  // decode
  logic           dev_hit;
  logic           wr_en;
  logic           rd_en;
  logic           hit_ctl;
  logic           hit_stat;
  logic           hit_ier;
  logic [NCH-1:0] hit_parm;
  logic [NCH-1:0] hit_fdata;

  // flag clear terms
  logic [NCH-1:0] drdy_clr;
  logic [NCH-1:0] ovf_clr;

  // register state
  logic [1:0]               ctl_q,      ctl_d;
  logic [NCH-1:0]           ier_drdy_q, ier_drdy_d;
  logic [NCH-1:0]           ier_ovf_q,  ier_ovf_d;
  logic [NCH-1:0][7:0]      dosr_q,     dosr_d;
  logic [NCH-1:0][1:0]      mod_q,      mod_d;
  logic [NCH-1:0][3:0]      div_q,      div_d;
  logic [NCH-1:0]           fen_q,      fen_d;
  logic [NCH-1:0]           aen_q,      aen_d;
  logic [NCH-1:0][1:0]      stf_q,      stf_d;
  logic [NCH-1:0][31:0]     fdata_q,    fdata_d;
  logic [NCH-1:0]           drdy_q,     drdy_d;
  logic [NCH-1:0]           ovf_q,      ovf_d;
  logic [31:0]              rdata_q,    rdata_d;
  logic                     rdvalid_q,  rdvalid_d;
  logic                     irq_q,      irq_d;

  // assembled read words
  logic [31:0] stat_word;
  logic [31:0] ier_word;

  // WDATA bits that map to no register field
  logic unused_wdata;
  assign unused_wdata = ^{WDATA[31:22], WDATA[19:18], WDATA[11:10]};

  // Address decode; only accesses to this device's page are acted on
  always_comb begin
    dev_hit   = (ADDR[15:8] == DEVADDR);
    wr_en     = dev_hit & WR;
    rd_en     = dev_hit & RD;
    hit_ctl   = (ADDR[7:0] == OFF_CTL);
    hit_stat  = (ADDR[7:0] == OFF_STAT);
    hit_ier   = (ADDR[7:0] == OFF_IER);
    hit_parm  = '0;
    hit_fdata = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_parm[i]  = (ADDR[7:0] == (OFF_PARM  + 8'(4 * i)));
      hit_fdata[i] = (ADDR[7:0] == (OFF_FDATA + 8'(4 * i)));
    end
  end

  // Next-state for control, enable and parameter registers and status flags
  always_comb begin
    ctl_d      = ctl_q;
    ier_drdy_d = ier_drdy_q;
    ier_ovf_d  = ier_ovf_q;
    dosr_d     = dosr_q;
    mod_d      = mod_q;
    div_d      = div_q;
    fen_d      = fen_q;
    aen_d      = aen_q;
    stf_d      = stf_q;
    fdata_d    = fdata_q;
    drdy_d     = drdy_q;
    ovf_d      = ovf_q;
    drdy_clr   = '0;
    ovf_clr    = '0;

    if (wr_en && hit_ctl) begin
      ctl_d = WDATA[1:0];
    end
    if (wr_en && hit_ier) begin
      ier_drdy_d = WDATA[NCH-1:0];
      ier_ovf_d  = WDATA[8 +: NCH];
    end

    for (int i = 0; i < NCH; i++) begin
      if (wr_en && hit_parm[i]) begin
        dosr_d[i] = WDATA[7:0];
        mod_d[i]  = WDATA[9:8];
        div_d[i]  = WDATA[15:12];
        fen_d[i]  = WDATA[16];
        aen_d[i]  = WDATA[17];
        stf_d[i]  = WDATA[21:20];
      end

      if (filt_data_update[i]) begin
        fdata_d[i] = filt_data_out[32*i +: 32];
      end

      // A clear is either a write-1 to STAT or an acknowledging FDATA read;
      // a same-cycle update wins over both, and an update that coincides
      // with a clear is a fresh sample rather than an overrun.
      drdy_clr[i] = (wr_en & hit_stat & WDATA[i]) |
                    (rd_en & hit_fdata[i] & aen_q[i]);
      ovf_clr[i]  = wr_en & hit_stat & WDATA[8+i];
      drdy_d[i]   = filt_data_update[i] | (drdy_q[i] & ~drdy_clr[i]);
      ovf_d[i]    = (filt_data_update[i] & drdy_q[i] & ~drdy_clr[i]) |
                    (ovf_q[i] & ~ovf_clr[i]);
    end

    // Interrupt follows the flags and enables as they will be after this edge
    irq_d = |{drdy_d & ier_drdy_d, ovf_d & ier_ovf_d};
  end

  // Read mux on pre-edge values; RDATA is forced to 0 when not qualified
  always_comb begin
    stat_word           = '0;
    stat_word[NCH-1:0]  = drdy_q;
    stat_word[8 +: NCH] = ovf_q;
    ier_word            = '0;
    ier_word[NCH-1:0]   = ier_drdy_q;
    ier_word[8 +: NCH]  = ier_ovf_q;

    rdvalid_d = rd_en;
    rdata_d   = '0;
    if (rd_en) begin
      if (hit_ctl) begin
        rdata_d = {30'b0, ctl_q};
      end else if (hit_stat) begin
        rdata_d = stat_word;
      end else if (hit_ier) begin
        rdata_d = ier_word;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (hit_parm[i]) begin
            rdata_d = {10'b0, stf_q[i], 2'b0, aen_q[i], fen_q[i],
                       div_q[i], 2'b0, mod_q[i], dosr_q[i]};
          end
          if (hit_fdata[i]) begin
            rdata_d = fdata_q[i];
          end
        end
      end
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      ctl_q      <= '0;
      ier_drdy_q <= '0;
      ier_ovf_q  <= '0;
      dosr_q     <= '0;
      mod_q      <= '0;
      div_q      <= '0;
      fen_q      <= '0;
      aen_q      <= '0;
      stf_q      <= '0;
      fdata_q    <= '0;
      drdy_q     <= '0;
      ovf_q      <= '0;
      rdata_q    <= '0;
      rdvalid_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctl_q      <= ctl_d;
      ier_drdy_q <= ier_drdy_d;
      ier_ovf_q  <= ier_ovf_d;
      dosr_q     <= dosr_d;
      mod_q      <= mod_d;
      div_q      <= div_d;
      fen_q      <= fen_d;
      aen_q      <= aen_d;
      stf_q      <= stf_d;
      fdata_q    <= fdata_d;
      drdy_q     <= drdy_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
      rdvalid_q  <= rdvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign reg_rsten   = ctl_q[0];
  assign reg_clken   = ctl_q[1];
  assign reg_filtdec = dosr_q;
  assign reg_inmode  = mod_q;
  assign reg_clkdiv  = div_q;
  assign reg_filten  = fen_q;
  assign reg_filtask = aen_q;
  assign reg_filtst  = stf_q;
  assign RDATA       = rdata_q;
  assign RDVALID     = rdvalid_q;
  assign irq         = irq_q;

endmodule
